td4_program_loader: RTL and testbench
=====================================

# td4_program_loader

Program-memory responder for the TD4 CPU core: a 16 x 8-bit instruction store that the CPU reads combinationally by its 4-bit program-counter address. The store is filled through a byte-wide valid/ready load port. A trailing checksum byte gates the release of the CPU. It sits between the external loader pins and the CPU's instruction-data input, and replaces a hard-wired ROM.

## Interface

Parameters:
- `NOP_INSTR`, default 8'h00. Byte driven on `instr` whenever the store is not in RUN. 8'h00 is ADD A,0 on TD4.

Ports:
- `clk`  input  1  Single system clock. All state changes on its rising edge.
- `rst`  input  1  Reset, asynchronous, active-high.
- `load_start`  input  1  Single-cycle pulse that begins or restarts a program load.
- `load_valid`  input  1  Loader has a byte on `load_data`.
- `load_data`  input  8  Program byte, or the checksum byte after 16 program bytes.
- `load_ready`  output  1  Block accepts a byte this cycle. A transfer occurs when `load_valid` and `load_ready` are both high at a rising edge.
- `addr`  input  4  CPU program-counter address.
- `instr`  output  8  Instruction byte presented to the CPU.
- `cpu_run`  output  1  High only in RUN. Drives the CPU reset/enable so the CPU executes only a verified program.
- `load_error`  output  1  High only in ERROR (checksum mismatch).
- `load_count`  output  5  Number of bytes accepted in the current load, 0..17, for status LEDs and debug.

## Operation

- Storage: 16 x 8 flip-flop array `mem`, all entries cleared to 8'h00 on `rst`. Entries are not cleared by `load_start`; they are only overwritten.
- State machine with states IDLE, LOAD, CHECK, RUN, ERROR. Reset state is IDLE.
- IDLE:
  - `load_ready`=0.
  - `load_start` moves to LOAD.
- LOAD:
  - `load_ready`=1.
  - On each transfer, `mem[load_count[3:0]]` <= `load_data`, `sum` <= `sum + load_data` (8-bit, modulo 256), and `load_count` increments.
  - The transfer that brings `load_count` to 16 moves to CHECK.
- CHECK:
  - `load_ready`=1.
  - On a transfer, `load_count` goes to 17 and the checksum byte is not written to `mem`.
  - If `(sum + load_data) mod 256 == 0` the next state is RUN; otherwise it is ERROR.
- RUN:
  - `load_ready`=0 and `cpu_run`=1.
  - `instr = mem[addr]`, a combinational read with no latency, so the CPU fetches in the same cycle the PC changes.
- ERROR:
  - `load_ready`=0, `load_error`=1 and `cpu_run`=0.
  - The state is held until `load_start` or `rst`.
- `instr` = `NOP_INSTR` in every state except RUN.
- `load_start` from any state, including LOAD and CHECK:
  - Next state is LOAD, with `load_count`=0 and `sum`=0.
  - A transfer in the same cycle as `load_start` is discarded: no `mem` write, no count or sum update.
- `load_valid` while `load_ready`=0 is ignored; no state change occurs.
- Bytes accepted in LOAD are written in strict address order 0..15. Addresses wrap naturally only through `load_count[3:0]`; the count never exceeds 17.

## Timing

- Reset values: `load_ready`=0, `cpu_run`=0, `load_error`=0, `load_count`=0, `instr`=`NOP_INSTR`, `sum`=0, all `mem` entries 8'h00.
- Asynchronous assertion of `rst` forces all of the above immediately, including mid-load and during RUN.
- Release of `rst` is sampled at the next rising edge.
- `load_start` sampled at edge N: `load_ready`=1 from cycle N+1.
- Minimum load time is 17 cycles after entering LOAD, at one transfer per cycle. Loader stalls (`load_valid`=0) insert cycles freely.
- Checksum transfer at edge M: from cycle M+1, either `cpu_run`=1 and `instr` shows `mem[addr]`, or `load_error`=1.
- `load_start` while in RUN at edge K: `cpu_run`=0 and `instr`=`NOP_INSTR` from cycle K+1.
- `instr` in RUN follows `addr` combinationally within the same cycle. Outputs other than `instr` are registered state decodes.

## Test plan

- Reset:
  - Stimulus: assert `rst` mid-cycle with random inputs.
  - Required response, immediately: `cpu_run`=0, `load_ready`=0, `load_error`=0, `load_count`=0, `instr`=8'h00.
  - After release, `load_valid`=1 with no `load_start` causes no state change.
- Good load:
  - Stimulus: `load_start`, then bytes 8'h00..8'h0F, then checksum 8'h88 (sum 8'h78).
  - Required response: `load_count`=17, `cpu_run`=1 the next cycle.
  - Then `addr`=5 gives `instr`=8'h05 and `addr`=15 gives 8'h0F in the same cycle.
- Bad checksum:
  - Stimulus: the same 16 bytes followed by checksum 8'h00.
  - Required response: `load_error`=1, `cpu_run`=0, `instr`=8'h00 for all `addr`.
  - A following `load_start` clears `load_error` the next cycle.
- Restart mid-load:
  - Stimulus: 7 bytes of 8'hAA, then `load_start` asserted together with a valid byte 8'hFF, then 16 bytes of 8'h11 and checksum 8'hF0.
  - Required response: the 8'hFF byte is discarded, `cpu_run`=1 at the end, and every address reads 8'h11.
- Stalled handshake:
  - Stimulus: `load_valid` toggled pseudo-randomly across a full load of 8'hB3,8'h5E,... with the correct checksum.
  - Required response: `load_count` increments only on valid&ready cycles, and the final memory contents match the golden model.
- Reload from RUN:
  - Stimulus: `load_start` while in RUN.
  - Required response: `cpu_run` drops and `instr`=8'h00 the next cycle.
  - Old contents persist in `mem` until overwritten, and are visible again after a successful reload if they are unchanged.

Source files
------------

// File: rtl/td4_program_loader.sv
// Program-memory responder for the TD4 CPU: a 16 x 8 instruction store filled over a
// byte-wide valid/ready port and released to the CPU only after a trailing checksum matches.
module td4_program_loader #(
    parameter logic [7:0] NOP_INSTR = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_start,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    input  logic [3:0] addr,
    output logic [7:0] instr,
    output logic       cpu_run,
    output logic       load_error,
    output logic [4:0] load_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t     state_r;
    logic [7:0] mem_r [16];
    logic [7:0] sum_r;
    logic       transfer_s;
    logic [7:0] chk_sum_s;

    // Handshake decode, checksum residue and the CPU-facing instruction mux.
    always_comb begin
        transfer_s = load_valid && load_ready;
        chk_sum_s  = sum_r + load_data;
        if (cpu_run) begin
            instr = mem_r[addr];
        end else begin
            instr = NOP_INSTR;
        end
    end

    // Instruction store; a restart pulse wins over any byte offered in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (!load_start && (state_r == ST_LOAD) && transfer_s) begin
            mem_r[load_count[3:0]] <= load_data;
        end
    end

    // Load sequencer with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            sum_r      <= 8'h00;
            load_count <= 5'd0;
            load_ready <= 1'b0;
            cpu_run    <= 1'b0;
            load_error <= 1'b0;
        end else if (load_start) begin
            state_r    <= ST_LOAD;
            sum_r      <= 8'h00;
            load_count <= 5'd0;
            load_ready <= 1'b1;
            cpu_run    <= 1'b0;
            load_error <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_LOAD: begin
                    if (transfer_s) begin
                        sum_r      <= sum_r + load_data;
                        load_count <= load_count + 5'd1;
                        if (load_count == 5'd15) begin
                            state_r <= ST_CHECK;
                        end else begin
                            state_r <= ST_LOAD;
                        end
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_CHECK: begin
                    if (transfer_s) begin
                        load_count <= 5'd17;
                        load_ready <= 1'b0;
                        if (chk_sum_s == 8'h00) begin
                            state_r <= ST_RUN;
                            cpu_run <= 1'b1;
                        end else begin
                            state_r    <= ST_ERROR;
                            load_error <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_CHECK;
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                end
                ST_ERROR: begin
                    state_r <= ST_ERROR;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    sum_r      <= 8'h00;
                    load_count <= 5'd0;
                    load_ready <= 1'b0;
                    cpu_run    <= 1'b0;
                    load_error <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_td4_program_loader.sv
// Self-checking bench for td4_program_loader: an abstract loader model checked every cycle,
// plus hand-computed literal expectations for the directed scenarios.
module tb_td4_program_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic [3:0] addr;
    logic [7:0] instr;
    logic       cpu_run;
    logic       load_error;
    logic [4:0] load_count;

    int checks = 0;
    int errors = 0;

    // Model: bytes accepted so far, running sum, verdict (0 none, 1 good, 2 bad).
    logic [7:0] m_mem [16];
    int         m_count;
    logic [7:0] m_sum;
    int         m_verdict;
    bit         m_loading;

    td4_program_loader dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .addr       (addr),
        .instr      (instr),
        .cpu_run    (cpu_run),
        .load_error (load_error),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at time %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_count   = 0;
        m_sum     = 8'h00;
        m_verdict = 0;
        m_loading = 1'b0;
    endfunction

    function automatic void model_step();
        bit rdy;
        rdy = m_loading && (m_count <= 16);
        if (load_start) begin
            m_loading = 1'b1;
            m_count   = 0;
            m_sum     = 8'h00;
            m_verdict = 0;
        end else if (rdy && load_valid) begin
            if (m_count < 16) begin
                m_mem[m_count] = load_data;
                m_sum          = m_sum + load_data;
                m_count        = m_count + 1;
            end else begin
                m_count   = 17;
                m_loading = 1'b0;
                m_verdict = (8'(m_sum + load_data) == 8'h00) ? 1 : 2;
            end
        end
    endfunction

    // Every cycle, shortly after the falling edge, compare all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            chk("ready", {7'd0, load_ready}, {7'd0, m_loading && (m_count <= 16)});
            chk("cpu_run", {7'd0, cpu_run}, {7'd0, m_verdict == 1});
            chk("load_error", {7'd0, load_error}, {7'd0, m_verdict == 2});
            chk("load_count", {3'd0, load_count}, 8'(m_count));
            chk("instr", instr, (m_verdict == 1) ? m_mem[addr] : 8'h00);
        end
    end

    task automatic drive(input logic s, input logic v, input logic [7:0] d, input logic [3:0] a);
        @(negedge clk);
        load_start = s;
        load_valid = v;
        load_data  = d;
        addr       = a;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    task automatic cyc(input logic s, input logic v, input logic [7:0] d, input logic [3:0] a);
        drive(s, v, d, a);
        tick();
    endtask

    task automatic load_bytes(input logic [7:0] first, input logic [7:0] step, input logic [7:0] csum);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'(first + step * i), 4'd0);
        cyc(1'b0, 1'b1, csum, 4'd0);
    endtask

    task automatic check_all(input string nm, input logic [7:0] first, input logic [7:0] step, input bit run);
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 1'b1, 8'h5A, 4'(a));
            chk(nm, instr, run ? 8'(first + step * a) : 8'h00);
            tick();
        end
    endtask

    task automatic reset_mid();
        @(negedge clk);
        load_start = 1'($urandom_range(0, 1));
        load_valid = 1'($urandom_range(0, 1));
        load_data  = 8'($urandom);
        addr       = 4'($urandom);
        #3 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_cpu_run", {7'd0, cpu_run}, 8'h00);
        chk("rst_ready", {7'd0, load_ready}, 8'h00);
        chk("rst_error", {7'd0, load_error}, 8'h00);
        chk("rst_count", {3'd0, load_count}, 8'h00);
        chk("rst_instr", instr, 8'h00);
        @(negedge clk);
        load_start = 1'b0;
        load_valid = 1'b1;
        rst        = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'($urandom), 4'($urandom));
        drive(1'b0, 1'b1, 8'h33, 4'd2);
        chk("idle_ready", {7'd0, load_ready}, 8'h00);
        chk("idle_count", {3'd0, load_count}, 8'h00);
        tick();
    endtask

    initial begin
        logic [7:0] d [17];
        logic [7:0] s;
        int acc;
        int budget;
        logic v;

        rst = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        addr       = 4'd0;
        model_reset();
        #12 rst = 1'b0;

        reset_mid();

        // Good load: 00..0F plus checksum 88.
        cyc(1'b1, 1'b0, 8'h00, 4'd0);
        drive(1'b0, 1'b0, 8'h00, 4'd0);
        chk("start_ready", {7'd0, load_ready}, 8'h01);
        tick();
        load_bytes(8'h00, 8'h01, 8'h88);
        drive(1'b0, 1'b0, 8'h00, 4'd5);
        chk("good_count", {3'd0, load_count}, 8'd17);
        chk("good_run", {7'd0, cpu_run}, 8'h01);
        chk("good_addr5", instr, 8'h05);
        addr = 4'd15;
        #1 chk("good_addr15", instr, 8'h0F);
        tick();

        // Reload from RUN, abort a partial load, then reload the same program.
        cyc(1'b1, 1'b0, 8'h00, 4'd5);
        drive(1'b0, 1'b0, 8'h00, 4'd5);
        chk("reload_run", {7'd0, cpu_run}, 8'h00);
        chk("reload_instr", instr, 8'h00);
        tick();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'hEE, 4'd0);
        cyc(1'b1, 1'b0, 8'h00, 4'd0);
        load_bytes(8'h00, 8'h01, 8'h88);
        check_all("reload_mem", 8'h00, 8'h01, 1'b1);

        // Bad checksum.
        cyc(1'b1, 1'b0, 8'h00, 4'd0);
        load_bytes(8'h00, 8'h01, 8'h00);
        drive(1'b0, 1'b1, 8'h00, 4'd7);
        chk("bad_error", {7'd0, load_error}, 8'h01);
        chk("bad_run", {7'd0, cpu_run}, 8'h00);
        tick();
        check_all("bad_instr", 8'h00, 8'h01, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 4'd0);
        drive(1'b0, 1'b0, 8'h00, 4'd0);
        chk("bad_cleared", {7'd0, load_error}, 8'h00);
        tick();

        // Restart mid-load with a discarded byte.
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 8'hAA, 4'd0);
        cyc(1'b1, 1'b1, 8'hFF, 4'd0);
        drive(1'b0, 1'b0, 8'h00, 4'd0);
        chk("restart_count", {3'd0, load_count}, 8'h00);
        tick();
        load_bytes(8'h11, 8'h00, 8'hF0);
        check_all("restart_mem", 8'h11, 8'h00, 1'b1);

        // Stalled handshake with a pseudo-random valid pattern.
        s = 8'h00;
        for (int i = 0; i < 16; i++) begin
            d[i] = 8'(8'hB3 + 8'hAB * i);
            s    = s + d[i];
        end
        d[16] = 8'(8'h00 - s);
        cyc(1'b1, 1'b0, 8'h00, 4'd0);
        acc = 0;
        budget = 0;
        while (acc < 17 && budget < 300) begin
            v = 1'($urandom_range(0, 1));
            cyc(1'b0, v, v ? d[acc] : 8'h77, 4'd0);
            if (v) acc++;
            budget++;
        end
        checks++;
        if (acc < 17) begin
            errors++;
            $display("FAIL stall_budget: got %0d bytes, expected 17", acc);
        end
        check_all("stall_mem", 8'hB3, 8'hAB, 1'b1);

        // Asynchronous reset while running.
        reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
